jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 113 +++++++++++
 tb/tb_jk_reg_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops clocked on the falling edge, with parallel load
// and synchronous up/down counting modes, terminal count and wrap pulse.
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qbar_r;
    logic             wrap_r;

    logic [WIDTH-1:0] up_tgl_s;
    logic [WIDTH-1:0] dn_tgl_s;
    logic [WIDTH-1:0] q_next_s;
    logic             wrap_next_s;
    logic             tc_s;

    // Toggle masks: bit i flips when every lower bit is 1 (up) or 0 (down)
    always_comb begin : toggle_masks
        logic up_c;
        logic dn_c;
        up_c     = 1'b1;
        dn_c     = 1'b1;
        up_tgl_s = ALL_ZEROS;
        dn_tgl_s = ALL_ZEROS;
        for (int i = 0; i < WIDTH; i++) begin
            up_tgl_s[i] = up_c;
            dn_tgl_s[i] = dn_c;
            up_c        = up_c & q_r[i];
            dn_c        = dn_c & ~q_r[i];
        end
    end

    // Next-state and wrap selection by operating mode
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        case (mode)
            MODE_JK: begin
                // J sets, K clears, both toggles, neither holds
                q_next_s = (J & ~q_r) | (~K & q_r);
            end
            MODE_LOAD: begin
                q_next_s = load_val;
            end
            MODE_UP: begin
                q_next_s    = q_r ^ up_tgl_s;
                wrap_next_s = (q_r == ALL_ONES);
            end
            MODE_DOWN: begin
                q_next_s    = q_r ^ dn_tgl_s;
                wrap_next_s = (q_r == ALL_ZEROS);
            end
            default: begin
                q_next_s    = q_r;
                wrap_next_s = 1'b0;
            end
        endcase
    end

    // Terminal count is a pure decode of current state and mode, ignoring en
    always_comb begin
        tc_s = 1'b0;
        case (mode)
            MODE_UP:   tc_s = (q_r == ALL_ONES);
            MODE_DOWN: tc_s = (q_r == ALL_ZEROS);
            default:   tc_s = 1'b0;
        endcase
    end

    // Falling-edge state registers; Qbar is its own flop fed with ~next
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= RST_VAL;
            qbar_r <= ~RST_VAL;
            wrap_r <= 1'b0;
        end else if (en) begin
            q_r    <= q_next_s;
            qbar_r <= ~q_next_s;
            wrap_r <= wrap_next_s;
        end else begin
            q_r    <= q_r;
            qbar_r <= qbar_r;
            wrap_r <= 1'b0;
        end
    end

    assign Q    = q_r;
    assign Qbar = qbar_r;
    assign wrap = wrap_r;
    assign tc   = tc_s;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed table on a 4-bit bank, hand
// sequences for reset/enable corners on an 8-bit bank, then randomized traffic.
module tb_jk_reg_bank;

    localparam logic [3:0] RST4 = 4'b1010;
    localparam logic [7:0] RST8 = 8'h5A;

    logic       clk;
    logic       rst_n;

    logic       d4_en, d4_tc, d4_wrap;
    logic [1:0] d4_mode;
    logic [3:0] d4_j, d4_k, d4_ld, d4_q, d4_qbar;

    logic       d8_en, d8_tc, d8_wrap;
    logic [1:0] d8_mode;
    logic [7:0] d8_j, d8_k, d8_ld, d8_q, d8_qbar;

    int nvec;
    int nmis;

    jk_reg_bank #(.WIDTH(4), .RST_VAL(RST4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(d4_en), .mode(d4_mode),
        .J(d4_j), .K(d4_k), .load_val(d4_ld),
        .Q(d4_q), .Qbar(d4_qbar), .tc(d4_tc), .wrap(d4_wrap)
    );

    jk_reg_bank #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(d8_en), .mode(d8_mode),
        .J(d8_j), .K(d8_k), .load_val(d8_ld),
        .Q(d8_q), .Qbar(d8_qbar), .tc(d8_tc), .wrap(d8_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] ld;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] q, input logic wr, input logic t);
        check({tag, ".q"},    {28'd0, d4_q},    {28'd0, q});
        check({tag, ".qbar"}, {28'd0, d4_qbar}, {28'd0, ~q});
        check({tag, ".wrap"}, {31'd0, d4_wrap}, {31'd0, wr});
        check({tag, ".tc"},   {31'd0, d4_tc},   {31'd0, t});
    endtask

    task automatic check8(input string tag, input logic [7:0] q, input logic wr, input logic t);
        check({tag, ".q"},    {24'd0, d8_q},    {24'd0, q});
        check({tag, ".qbar"}, {24'd0, d8_qbar}, {24'd0, ~q});
        check({tag, ".wrap"}, {31'd0, d8_wrap}, {31'd0, wr});
        check({tag, ".tc"},   {31'd0, d8_tc},   {31'd0, t});
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    // Reference model: returns {wrap, next_q} computed from the mode rules
    function automatic logic [32:0] ref_next(input int w, input logic [31:0] q,
                                             input logic [1:0] md, input logic [31:0] j,
                                             input logic [31:0] k, input logic [31:0] ld,
                                             input logic e);
        logic [31:0] mask;
        logic [31:0] nq;
        logic        wr;
        mask = (32'd1 << w) - 32'd1;
        nq   = q;
        wr   = 1'b0;
        if (e) begin
            case (md)
                2'd0: for (int i = 0; i < w; i++) begin
                    if (j[i] && k[i])  nq[i] = ~q[i];
                    else if (j[i])     nq[i] = 1'b1;
                    else if (k[i])     nq[i] = 1'b0;
                    else               nq[i] = q[i];
                end
                2'd1: nq = ld & mask;
                2'd2: begin nq = (q + 32'd1) & mask; wr = (q == mask); end
                default: begin nq = (q - 32'd1) & mask; wr = (q == 32'd0); end
            endcase
        end
        return {wr, nq};
    endfunction

    function automatic logic ref_tc(input int w, input logic [31:0] q, input logic [1:0] md);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (md == 2'd2 && q == mask) || (md == 2'd3 && q == 32'd0);
    endfunction

    initial begin
        logic [32:0] r;
        logic [3:0]  m4;
        logic [7:0]  m8;
        logic        w4, w8;
        logic [7:0]  picks[5];

        nvec = 0;
        nmis = 0;

        //            en    mode   J        K        ld       Q        wrap  tc
        tbl[0]  = '{1'b1, 2'b00, 4'b1100, 4'b0110, 4'b0000, 4'b1100, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 4'b0000, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0};

        rst_n   = 1'b1;
        d4_en   = 1'b0; d4_mode = 2'b00; d4_j = 4'd0; d4_k = 4'd0; d4_ld = 4'd0;
        d8_en   = 1'b0; d8_mode = 2'b00; d8_j = 8'd0; d8_k = 8'd0; d8_ld = 8'd0;

        // Asynchronous reset takes effect with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check4("rst_async4", RST4, 1'b0, 1'b0);
        check8("rst_async8", RST8, 1'b0, 1'b0);

        // Edges during reset are ignored even with counting enabled
        d4_en = 1'b1; d4_mode = 2'b10;
        fall();
        fall();
        check4("rst_hold4", RST4, 1'b0, 1'b0);

        // Release mid-high phase; the very next falling edge acts
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            d4_en = tbl[i].en; d4_mode = tbl[i].mode;
            d4_j  = tbl[i].j;  d4_k    = tbl[i].k; d4_ld = tbl[i].ld;
            fall();
            check4($sformatf("tbl%0d", i), tbl[i].q, tbl[i].wrap, tbl[i].tc);
        end
        d4_en = 1'b0;
        check8("d8_idle", RST8, 1'b0, 1'b0);

        // 8-bit: load, count, freeze for three edges, resume
        d8_en = 1'b1; d8_mode = 2'b01; d8_ld = 8'h37;
        fall();
        check8("d8_load", 8'h37, 1'b0, 1'b0);
        d8_mode = 2'b10;
        fall();
        check8("d8_cnt", 8'h38, 1'b0, 1'b0);
        d8_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fall();
            check8($sformatf("d8_frz%0d", i), 8'h38, 1'b0, 1'b0);
        end
        d8_en = 1'b1;
        fall();
        check8("d8_resume", 8'h39, 1'b0, 1'b0);

        // Reset pulse between edges discards the count
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check8("d8_rst_mid", RST8, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        fall();
        check8("d8_after_rst", RST8 + 8'd1, 1'b0, 1'b0);
        check4("d4_after_rst", RST4, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        m4 = RST4;
        m8 = RST8 + 8'd1;
        picks[0] = 8'hFF; picks[1] = 8'h00; picks[2] = 8'hFE; picks[3] = 8'h01; picks[4] = 8'h80;
        for (int c = 0; c < 400; c++) begin
            d4_en   = ($urandom_range(9) != 0);
            d4_mode = 2'($urandom_range(3));
            d4_j    = 4'($urandom); d4_k = 4'($urandom);
            d4_ld   = 4'($urandom);
            d8_en   = ($urandom_range(9) != 0);
            d8_mode = 2'($urandom_range(3));
            d8_j    = 8'($urandom); d8_k = 8'($urandom);
            d8_ld   = ($urandom_range(1) == 0) ? picks[$urandom_range(4)] : 8'($urandom);
            r  = ref_next(4, {28'd0, m4}, d4_mode, {28'd0, d4_j}, {28'd0, d4_k}, {28'd0, d4_ld}, d4_en);
            m4 = r[3:0];
            w4 = r[32];
            r  = ref_next(8, {24'd0, m8}, d8_mode, {24'd0, d8_j}, {24'd0, d8_k}, {24'd0, d8_ld}, d8_en);
            m8 = r[7:0];
            w8 = r[32];
            fall();
            check4($sformatf("rnd4_%0d", c), m4, w4, ref_tc(4, {28'd0, m4}, d4_mode));
            check8($sformatf("rnd8_%0d", c), m8, w8, ref_tc(8, {24'd0, m8}, d8_mode));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
